// File: rtl/mem_sched_pkg.sv
// Purpose : shared types and default sizes for the memory access scheduler.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: sched_state_t FSM encoding, data_t default data word, default sizes.
package mem_sched_pkg;

  localparam int NUM_PROC_DEF  = 4;
  localparam int DATA_SIZE_DEF = 2;   // bytes per block
  localparam int ADDR_W_DEF    = 13;  // 16 KiB / 2-byte blocks
  localparam int LATENCY_DEF   = 10;  // mem_req to valid mem_rdata

  typedef logic [DATA_SIZE_DEF*8-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : round-robin pick of the first pending requester at or above rr_ptr, wrapping.
// Latency : purely combinational, grant valid in the same cycle as req.
// Backpr. : none; the caller decides whether the grant is consumed.
// Ports   : req (pending vector), rr_ptr (search start) -> grant (one-hot),
//           winner (binary index of grant), any_valid (some req bit set).
module rr_arbiter #(
  parameter int NUM_PROCESSORS = 4,
  localparam int PW = $clog2(NUM_PROCESSORS)
) (
  input  logic [NUM_PROCESSORS-1:0] req,
  input  logic [PW-1:0]             rr_ptr,
  output logic [NUM_PROCESSORS-1:0] grant,
  output logic [PW-1:0]             winner,
  output logic                      any_valid
);

  logic [PW-1:0] idx;
  logic          found;

  // Walk NUM_PROCESSORS positions starting at rr_ptr; the wrap is an explicit
  // compare so a non-power-of-two requester count never visits a hole.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int i = 0; i < NUM_PROCESSORS; i++) begin
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
      if (idx == PW'(NUM_PROCESSORS - 1)) idx = '0;
      else                                idx = idx + 1'b1;
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/mem_access_scheduler.sv
// Purpose : round-robin sharing of one fixed-latency single-port memory among requesters.
// Latency : accept T, mem_req T+1, resp_valid T+2+LATENCY, next accept >= T+3+LATENCY.
// Backpr. : one op in flight; req_ready held low outside IDLE, requesters hold req_valid.
// Ports   : req_* per-requester request (packed, requester i at slice i), req_ready/resp_valid
//           one-hot pulses, resp_data read data (0 for writes), mem_* memory master side,
//           busy high outside IDLE. Optional MEM_SCHED_LOCK_EN: req_lock keeps ownership
//           for one further op; without it req_lock is ignored.
module mem_access_scheduler
  import mem_sched_pkg::*;
#(
  parameter int NUM_PROCESSORS = NUM_PROC_DEF,
  parameter int DATA_SIZE      = DATA_SIZE_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int LATENCY        = LATENCY_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PROCESSORS-1:0]           req_valid,
  input  logic [NUM_PROCESSORS-1:0]           req_we,
  input  logic [NUM_PROCESSORS-1:0]           req_lock,
  input  logic [NUM_PROCESSORS*ADDR_W-1:0]    req_addr,
  input  logic [NUM_PROCESSORS*DATA_SIZE*8-1:0] req_wdata,
  output logic [NUM_PROCESSORS-1:0]           req_ready,
  output logic [NUM_PROCESSORS-1:0]           resp_valid,
  output logic [DATA_SIZE*8-1:0]              resp_data,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [DATA_SIZE*8-1:0]              mem_wdata,
  input  logic [DATA_SIZE*8-1:0]              mem_rdata,
  output logic                                busy
);

  localparam int DW = DATA_SIZE * 8;
  localparam int PW = $clog2(NUM_PROCESSORS);
  localparam int CW = $clog2(LATENCY + 1);

  sched_state_t state, state_nxt;

  logic [PW-1:0]     rr_ptr;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     resp_data_q;

  logic [NUM_PROCESSORS-1:0] grant;
  logic [PW-1:0]             win_idx;
  logic                      any_valid;

  logic [ADDR_W-1:0] addr_arr  [NUM_PROCESSORS];
  logic [DW-1:0]     wdata_arr [NUM_PROCESSORS];

  for (genvar g = 0; g < NUM_PROCESSORS; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DW +: DW];
  end

  rr_arbiter #(
    .NUM_PROCESSORS(NUM_PROCESSORS)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .winner    (win_idx),
    .any_valid (any_valid)
  );

  // Pointer after a normal (unlocked) completion: one past the last winner.
  logic [PW-1:0] rr_next;
  assign rr_next = (win_q == PW'(NUM_PROCESSORS - 1)) ? '0 : win_q + 1'b1;

`ifdef MEM_SCHED_LOCK_EN
  logic lock_q;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req_ready = grant;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        resp_valid[win_q] = 1'b1;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // No handshake may complete while reset is asserted.
    if (reset) begin
      req_ready  = '0;
      resp_valid = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      cnt         <= '0;
      win_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
`ifdef MEM_SCHED_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            win_q   <= win_idx;
            we_q    <= req_we[win_idx];
            addr_q  <= addr_arr[win_idx];
            wdata_q <= wdata_arr[win_idx];
`ifdef MEM_SCHED_LOCK_EN
            lock_q  <= req_lock[win_idx];
`endif
          end
        end
        ISSUE: cnt <= CW'(LATENCY - 1);
        WAIT: begin
          if (cnt == '0) resp_data_q <= we_q ? '0 : mem_rdata;
          else           cnt         <= cnt - 1'b1;
        end
        RESP: begin
`ifdef MEM_SCHED_LOCK_EN
          // A locked op parks the pointer on its owner for exactly one more arbitration.
          rr_ptr <= lock_q ? win_q : rr_next;
`else
          rr_ptr <= rr_next;
`endif
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = (state == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign resp_data = resp_data_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Purpose : directed self-checking bench for mem_access_scheduler with a fixed-latency memory model.
// Latency : model returns read data exactly LATENCY cycles after mem_req.
// Backpr. : requesters hold req_valid until their req_ready pulse.
module tb_mem_access_scheduler;
  import mem_sched_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 13;
  localparam int DS  = 2;
  localparam int LAT = 10;
  localparam int DW  = DS * 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, resp_valid;
  logic [DW-1:0]   resp_data;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mem_access_scheduler #(
    .NUM_PROCESSORS(N), .DATA_SIZE(DS), .ADDR_W(AW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: write on the mem_req edge, read data travels a LATENCY-deep
  // pipe and is only driven in its valid cycle; 0xDEAD otherwise.
  logic [DW-1:0]  mem [0:(1<<AW)-1];
  logic [DW-1:0]  pd  [LAT];
  logic [LAT-1:0] pv = '0;

  always @(posedge clk) begin
    if (reset) mem[5] <= 16'hBEEF;
    else if (mem_req && mem_we) mem[mem_addr] <= mem_wdata;
    pv    <= {pv[LAT-2:0], mem_req & ~mem_we};
    pd[0] <= mem[mem_addr];
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end

  assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic wait_grant(output int idx, output int t);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 100) begin
      @(posedge clk); #2; n++;
    end
    check("grant_timeout", 32'(n < 100), 1);
    check("grant_onehot", $countones(req_ready), 1);
    idx = 0;
    for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
    t = cyc;
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(output int t);
    int n = 0;
    while (resp_valid == '0 && n < 100) begin
      step(1); n++;
    end
    check("resp_timeout", 32'(n < 100), 1);
    t = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      step(1); n++;
    end
    check("idle_timeout", 32'(n < 100), 1);
  endtask

  task automatic single_op(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] expd, input string tag);
    int g, t0, t1;
    req_valid[p]          = 1'b1;
    req_we[p]             = we;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = wd;
    wait_grant(g, t0);
    req_valid[p] = 1'b0;
    check({tag, "_winner"}, g, p);
    check({tag, "_mreq"}, mem_req, 1);
    check({tag, "_mwe"}, mem_we, we);
    check({tag, "_maddr"}, mem_addr, a);
    if (we) check({tag, "_mwdata"}, mem_wdata, wd);
    step(1);
    check({tag, "_mreq_once"}, mem_req, 0);
    check({tag, "_busy"}, busy, 1);
    wait_resp(t1);
    check({tag, "_lat"}, t1 - t0, LAT + 2);
    check({tag, "_rvld"}, resp_valid, 32'(1) << p);
    check({tag, "_rdata"}, resp_data, expd);
    step(1);
    check({tag, "_rvld_once"}, resp_valid, 0);
    check({tag, "_rdata_hold"}, resp_data, expd);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g[5];
    int t[5];
    int ord[5] = '{0, 1, 2, 3, 0};
    int lk[3];
    int seen;
    int t_last;
`ifdef MEM_SCHED_LOCK_EN
    int lk_exp[3] = '{1, 1, 2};
`else
    int lk_exp[3] = '{1, 2, 1};
`endif

    reset = 1'b1; req_valid = '0; req_we = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0;
    step(3);
    check("rst_ready", req_ready, 0);
    check("rst_rvld", resp_valid, 0);
    check("rst_rdata", resp_data, 0);
    check("rst_mreq", mem_req, 0);
    check("rst_mwe", mem_we, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_mwdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // Contention: everyone always pending -> strict rotation, 13 cycles apart.
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) wait_grant(g[k], t[k]);
    req_valid = '0;
    for (int k = 0; k < 5; k++) check($sformatf("cont_order%0d", k), g[k], ord[k]);
    for (int k = 1; k < 5; k++) check($sformatf("cont_gap%0d", k), t[k] - t[k-1], LAT + 3);
    wait_idle();

    // Single read of the preloaded word.
    single_op(2, 1'b0, 13'h005, 16'h0000, 16'hBEEF, "rd");
    // Write then read back; write acknowledges with zero data.
    single_op(0, 1'b1, 13'h0A0, 16'h1234, 16'h0000, "wr");
    single_op(0, 1'b0, 13'h0A0, 16'h0000, 16'h1234, "rdbk");

    // Sparse round-robin: after P3, P1 beats P2.
    single_op(3, 1'b0, 13'h005, 16'h0000, 16'hBEEF, "p3");
    req_valid[1] = 1'b1; req_valid[2] = 1'b1;
    wait_grant(g[0], t[0]);
    req_valid[1] = 1'b0;
    wait_grant(g[1], t[1]);
    req_valid[2] = 1'b0;
    check("sparse_first", g[0], 1);
    check("sparse_second", g[1], 2);
    wait_idle();

    // Reset five cycles after mem_req abandons the access.
    req_valid[2] = 1'b1;
    req_addr[2*AW +: AW] = 13'h005;
    wait_grant(g[0], t[0]);
    req_valid[2] = 1'b0;
    check("abort_winner", g[0], 2);
    check("abort_mreq", mem_req, 1);
    step(5);
    reset = 1'b1;
    step(1);
    check("abort_rvld", resp_valid, 0);
    check("abort_mreq_clr", mem_req, 0);
    check("abort_busy", busy, 0);
    check("abort_rdata", resp_data, 0);
    check("abort_maddr", mem_addr, 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid != '0) seen++;
      step(1);
    end
    check("abort_no_resp", seen, 0);
    // Pointer back at 0: P1 ahead of P3.
    req_valid[1] = 1'b1; req_valid[3] = 1'b1;
    wait_grant(g[0], t[0]);
    req_valid[1] = 1'b0;
    wait_grant(g[1], t[1]);
    req_valid[3] = 1'b0;
    check("post_rst_first", g[0], 1);
    check("post_rst_second", g[1], 3);
    wait_idle();

    // Lock: P1 locks its first op only, P2 competing.
    req_valid[1] = 1'b1; req_valid[2] = 1'b1; req_lock[1] = 1'b1;
    wait_grant(lk[0], t_last);
    req_lock[1] = 1'b0;
    wait_grant(lk[1], t_last);
    if (lk[1] == 2) req_valid[2] = 1'b0;
    wait_grant(lk[2], t_last);
    req_valid = '0;
    for (int k = 0; k < 3; k++) check($sformatf("lock_order%0d", k), lk[k], lk_exp[k]);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
